// File: rtl/tdm_transceiver.sv
// I2S / TDM serial audio transceiver, master-clock domain only.
// Generates sclk/ws by counting and moves whole frames with strobes.
module tdm_transceiver #(
  parameter int d_width         = 24,
  parameter int n_ch            = 2,
  parameter int slot_width      = 32,
  parameter int mclk_sclk_ratio = 4,
  parameter int lj_mode         = 0
) (
  input  logic                    mclk,
  input  logic                    reset_n,
  output logic                    sclk,
  output logic                    ws,
  input  logic                    sd_rx,
  output logic                    sd_tx,
  input  logic [n_ch*d_width-1:0] tx_data,
  output logic                    tx_load,
  output logic [n_ch*d_width-1:0] rx_data,
  output logic                    rx_valid
);

  localparam int H   = mclk_sclk_ratio / 2;
  localparam int CW  = (H > 1) ? $clog2(H) : 1;
  localparam int OW  = $clog2(slot_width);
  localparam int OW1 = OW + 1;
  localparam int SW  = $clog2(n_ch);
  localparam int TW  = n_ch * d_width;
  localparam int IW  = $clog2(TW);

  localparam logic [CW-1:0]  CNT_MAX  = CW'(H - 1);
  localparam logic [OW-1:0]  OFF_MAX  = OW'(slot_width - 1);
  localparam logic [SW-1:0]  SLOT_MAX = SW'(n_ch - 1);
  localparam logic [OW1-1:0] DLY      = OW1'(1 - lj_mode);
  localparam logic [OW1-1:0] DWL      = OW1'(d_width);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic [OW-1:0] off_q, off_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          ws_q, ws_d;
  logic          sd_tx_q, sd_tx_d;
  logic [TW-1:0] tx_buf_q, tx_buf_d;
  logic [TW-1:0] rx_asm_q, rx_asm_d;
  logic [TW-1:0] rx_data_q, rx_data_d;
  logic          tx_load_q, tx_load_d;
  logic          rx_valid_q, rx_valid_d;
  logic          primed_q, primed_d;

  logic           tick, rise, fall, wrap;
  logic [OW-1:0]  nxt_off;
  logic [SW-1:0]  nxt_slot;
  logic [OW1-1:0] tx_bit, rx_bit;
  logic           tx_ok, rx_ok;
  logic [IW-1:0]  tx_idx, rx_idx;
  logic [TW-1:0]  tx_src;

  always_comb begin
    tick = (cnt_q == CNT_MAX);
    rise = tick & ~sclk_q;
    fall = tick & sclk_q;
    wrap = fall && (off_q == OFF_MAX) && (slot_q == SLOT_MAX);

    nxt_off  = off_q + OW'(1);
    nxt_slot = slot_q;
    if (off_q == OFF_MAX) begin
      nxt_off  = '0;
      nxt_slot = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
    end

    // Wrapped subtraction lands far above d_width for leading pad bits.
    tx_bit = {1'b0, nxt_off} - DLY;
    tx_ok  = tx_bit < DWL;
    tx_idx = IW'(int'(nxt_slot) * d_width + d_width - 1 - int'(tx_bit));
    rx_bit = {1'b0, off_q} - DLY;
    rx_ok  = rx_bit < DWL;
    rx_idx = IW'(int'(slot_q) * d_width + d_width - 1 - int'(rx_bit));
    tx_src = wrap ? tx_data : tx_buf_q;
  end

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    sclk_d     = tick ? ~sclk_q : sclk_q;
    off_d      = off_q;
    slot_d     = slot_q;
    ws_d       = ws_q;
    sd_tx_d    = sd_tx_q;
    tx_buf_d   = tx_buf_q;
    rx_asm_d   = rx_asm_q;
    rx_data_d  = rx_data_q;
    tx_load_d  = 1'b0;
    rx_valid_d = 1'b0;
    primed_d   = primed_q;

    if (rise && rx_ok) begin
      rx_asm_d[rx_idx] = sd_rx;
    end

    if (fall) begin
      off_d   = nxt_off;
      slot_d  = nxt_slot;
      sd_tx_d = tx_ok ? tx_src[tx_idx] : 1'b0;
      if (n_ch == 2) begin
        ws_d = nxt_slot[0];
      end else begin
        ws_d = (nxt_off == '0) && (nxt_slot == '0);
      end
    end

    // First frame after reset is partial, so its rx strobe is held off.
    if (wrap) begin
      tx_buf_d   = tx_data;
      tx_load_d  = 1'b1;
      rx_data_d  = primed_q ? rx_asm_q : rx_data_q;
      rx_valid_d = primed_q;
      primed_d   = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      off_q      <= OFF_MAX;
      slot_q     <= SLOT_MAX;
      ws_q       <= 1'b0;
      sd_tx_q    <= 1'b0;
      tx_buf_q   <= '0;
      rx_asm_q   <= '0;
      rx_data_q  <= '0;
      tx_load_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      off_q      <= off_d;
      slot_q     <= slot_d;
      ws_q       <= ws_d;
      sd_tx_q    <= sd_tx_d;
      tx_buf_q   <= tx_buf_d;
      rx_asm_q   <= rx_asm_d;
      rx_data_q  <= rx_data_d;
      tx_load_q  <= tx_load_d;
      rx_valid_q <= rx_valid_d;
      primed_q   <= primed_d;
    end
  end

  assign sclk     = sclk_q;
  assign ws       = ws_q;
  assign sd_tx    = sd_tx_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
